keccak_rho_scheduler: RTL



---
 rtl/keccak_pkg.sv | 22 ++
 rtl/BiRotR.sv | 24 ++
 rtl/keccak_rho_scheduler.sv | 74 +++++++
 3 files changed

// File: rtl/keccak_pkg.sv
// Shared Keccak-f[1600] constants for the rho stage: lane geometry, rho offsets, 32-bit rotate helper.
// Offsets are rotate-left amounts in the plain (non-interleaved) lane domain, indexed by x+5y.
package keccak_pkg;
  localparam int LANE_W    = 64;
  localparam int NUM_LANES = 25;

  typedef logic [4:0] lane_idx_t;

  localparam logic [5:0] RHO_OFFS [0:24] = '{
    6'd0,  6'd1,  6'd62, 6'd28, 6'd27,
    6'd36, 6'd44, 6'd6,  6'd55, 6'd20,
    6'd3,  6'd10, 6'd43, 6'd25, 6'd39,
    6'd41, 6'd45, 6'd15, 6'd21, 6'd8,
    6'd18, 6'd2,  6'd61, 6'd56, 6'd14
  };

  function automatic logic [31:0] rotr32(input logic [31:0] x, input logic [4:0] s);
    logic [63:0] t;
    t = {x, x} >> s;
    return t[31:0];
  endfunction
endpackage

// File: rtl/BiRotR.sv
// Bit-interleaved 64-bit rotate-right: lane is {odd bits, even bits}, amt is the plain-domain rotate.
// Purely combinational; odd amounts swap the halves and give the even half one extra step.
module BiRotR
  import keccak_pkg::*;
(
  input  logic [LANE_W-1:0] din,
  input  logic [5:0]        amt,
  output logic [LANE_W-1:0] dout
);
  logic [4:0] k;
  logic [4:0] k1;

  assign k  = amt[5:1];
  assign k1 = k + 5'd1;

  always_comb begin
    if (amt[0]) begin
      // even' = odd >> k, odd' = even >> (k+1); k+1 == 32 wraps to identity
      dout = {rotr32(din[31:0], k1), rotr32(din[63:32], k)};
    end else begin
      dout = {rotr32(din[63:32], k), rotr32(din[31:0], k)};
    end
  end
endmodule

// File: rtl/keccak_rho_scheduler.sv
// Streams 25 interleaved lanes through one shared rotator applying rho, with a 1-cycle registered output.
// Optional synchronous frame abort when KECCAK_RHO_ABORT_EN is defined.
module keccak_rho_scheduler
  import keccak_pkg::*;
#(
  parameter int LANES = NUM_LANES
) (
  input  logic              clk,
  input  logic              rst,
`ifdef KECCAK_RHO_ABORT_EN
  input  logic              abort,
`endif
  input  logic [LANE_W-1:0] lane_in,
  input  logic              lane_in_valid,
  output logic              lane_in_ready,
  output logic [LANE_W-1:0] lane_out,
  output lane_idx_t         lane_out_idx,
  output logic              lane_out_valid,
  input  logic              lane_out_ready,
  output logic              frame_done,
  output logic              busy
);
  localparam lane_idx_t LAST_IDX = lane_idx_t'(LANES - 1);

  lane_idx_t         idx_q;
  logic [5:0]        rot_amt;
  logic [LANE_W-1:0] rot_dat;
  logic              in_hs;
  logic              out_hs;
  logic              kill;

`ifdef KECCAK_RHO_ABORT_EN
  assign kill = abort;
`else
  assign kill = 1'b0;
`endif

  assign lane_in_ready = (!lane_out_valid || lane_out_ready) && !kill;
  assign in_hs         = lane_in_valid && lane_in_ready;
  assign out_hs        = lane_out_valid && lane_out_ready;
  // Left rotate by r == right rotate by (64 - r) mod 64; the 6-bit wrap maps r=0 to 0.
  assign rot_amt       = 6'd0 - RHO_OFFS[idx_q];
  assign busy          = (idx_q != '0) || lane_out_valid;

  BiRotR u_rot (
    .din  (lane_in),
    .amt  (rot_amt),
    .dout (rot_dat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q          <= '0;
      lane_out       <= '0;
      lane_out_idx   <= '0;
      lane_out_valid <= 1'b0;
      frame_done     <= 1'b0;
    end else if (kill) begin
      idx_q          <= '0;
      lane_out_valid <= 1'b0;
      frame_done     <= 1'b0;
    end else begin
      frame_done <= out_hs && (lane_out_idx == LAST_IDX);
      if (in_hs) begin
        idx_q          <= (idx_q == LAST_IDX) ? '0 : idx_q + 5'd1;
        lane_out       <= rot_dat;
        lane_out_idx   <= idx_q;
        lane_out_valid <= 1'b1;
      end else if (out_hs) begin
        lane_out_valid <= 1'b0;
      end
    end
  end
endmodule
